bus_mux_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the 8-bit, 4:1 bus mux. Four requesters each present one 8-bit data word with a request line. The block grants the shared bus to one requester at a time and drives the mux select. It delivers the selected word to a single downstream sink over a valid/ready handshake and acknowledges the winning requester on each completed beat.

---
 rtl/bus_mux_arbiter.sv | 143 ++++++++++++++
 tb/tb_bus_mux_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_mux_arbiter.sv
// bus_mux_arbiter: round-robin arbiter and sequencer for an 8-bit, 4:1 bus mux.
// Four requesters each present one data byte and a request line. One requester at a
// time is granted the bus. Its byte goes to a single sink over a valid/ready handshake,
// and each completed beat is acknowledged to the winner.
//
// Ports:
//   clk      - clock, rising edge
//   rst_n    - asynchronous active-low reset
//   i_req    - request lines, bit k = requester k
//   i_data   - packed requester bytes, requester k owns [8k+7:8k]
//   i_ready  - sink accepts o_data this cycle
//   o_gnt    - one-hot grant, zero when idle
//   o_sel    - binary index of the granted requester (mux select)
//   o_valid  - o_data valid for the sink
//   o_data   - i_data byte selected by o_sel
//   o_ack    - one-hot beat-accepted pulse to the granted requester
//
// Configuration macro: ARB_BURST_EN. When it is defined, a requester may keep the grant
// for up to MAX_BURST consecutive beats. When it is undefined, every beat ends the grant.
module bus_mux_arbiter #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  i_req,
  input  logic [31:0] i_data,
  input  logic        i_ready,
  output logic [3:0]  o_gnt,
  output logic [1:0]  o_sel,
  output logic        o_valid,
  output logic [7:0]  o_data,
  output logic [3:0]  o_ack
);

  localparam logic StIdle  = 1'b0;
  localparam logic StGrant = 1'b1;

  logic       r_state, w_state_d;
  logic [1:0] r_sel, w_sel_d;
  logic [1:0] r_last, w_last_d;
  logic [3:0] r_gnt, w_gnt_d;
  logic [1:0] w_win;
  logic       w_win_any;
  logic       w_beat;
  logic       w_do_arb;
  logic       w_go_idle;

`ifdef ARB_BURST_EN
  logic [3:0] r_beats, w_beats_d;
`else
  // The burst length is meaningful only when bursts are compiled in.
  logic w_unused_burst;
  assign w_unused_burst = (MAX_BURST > 0);
`endif

  assign o_valid = (r_state == StGrant) & i_req[r_sel];
  assign w_beat  = o_valid & i_ready;
  assign o_ack   = w_beat ? r_gnt : 4'b0000;
  assign o_data  = i_data[{r_sel, 3'b000} +: 8];
  assign o_gnt   = r_gnt;
  assign o_sel   = r_sel;

  // Search starts one past the last winner, so the last winner gets the lowest priority.
  always_comb begin
    w_win     = r_last;
    w_win_any = 1'b0;
    for (int unsigned k = 1; k <= 4; k++) begin
      if (!w_win_any && i_req[r_last + 2'(k)]) begin
        w_win     = r_last + 2'(k);
        w_win_any = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_sel_d   = r_sel;
    w_gnt_d   = r_gnt;
    w_last_d  = r_last;
    w_do_arb  = 1'b0;
    w_go_idle = 1'b0;
`ifdef ARB_BURST_EN
    w_beats_d = r_beats;
`endif
    unique case (r_state)
      StIdle: w_do_arb = w_win_any;
      StGrant: begin
        if (w_beat) begin
`ifdef ARB_BURST_EN
          if (i_req[r_sel] && ((32'(r_beats) + 32'd1) < MAX_BURST)) begin
            w_beats_d = r_beats + 4'd1;
          end else begin
            w_do_arb  = w_win_any;
            w_go_idle = !w_win_any;
          end
`else
          w_do_arb  = w_win_any;
          w_go_idle = !w_win_any;
`endif
        end else if (!i_req[r_sel]) begin
          // The owner withdrew. Drop the grant and re-arbitrate from idle next cycle.
          w_go_idle = 1'b1;
        end
      end
      default: w_go_idle = 1'b1;
    endcase

    if (w_do_arb) begin
      w_state_d = StGrant;
      w_sel_d   = w_win;
      w_gnt_d   = 4'b0001 << w_win;
      w_last_d  = w_win;
`ifdef ARB_BURST_EN
      w_beats_d = 4'd0;
`endif
    end
    if (w_go_idle) begin
      w_state_d = StIdle;
      w_gnt_d   = 4'b0000;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_sel   <= 2'd0;
      r_gnt   <= 4'b0000;
      r_last  <= 2'd3;
`ifdef ARB_BURST_EN
      r_beats <= 4'd0;
`endif
    end else begin
      r_state <= w_state_d;
      r_sel   <= w_sel_d;
      r_gnt   <= w_gnt_d;
      r_last  <= w_last_d;
`ifdef ARB_BURST_EN
      r_beats <= w_beats_d;
`endif
    end
  end

endmodule

// File: tb/tb_bus_mux_arbiter.sv
// Testbench for bus_mux_arbiter. The bench runs directed scenarios and then random
// traffic. A requester-level reference model predicts every accepted beat into a
// scoreboard queue. A negedge monitor pops an entry on each DUT beat and compares it.
module tb_bus_mux_arbiter;

  localparam int unsigned MaxBurst = 4;
`ifdef ARB_BURST_EN
  localparam int BurstLimit = MaxBurst;
`else
  localparam int BurstLimit = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] data;
  logic        ready;
  logic [3:0]  o_gnt;
  logic [1:0]  o_sel;
  logic        o_valid;
  logic [7:0]  o_data;
  logic [3:0]  o_ack;

  bus_mux_arbiter #(.MAX_BURST(MaxBurst)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_req   (req),
    .i_data  (data),
    .i_ready (ready),
    .o_gnt   (o_gnt),
    .o_sel   (o_sel),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_ack   (o_ack)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [9:0] sb[$];  // {winner index, byte}

  // Reference model: who owns the bus (-1 = nobody), the last winner, and the beats taken.
  int m_owner, m_last, m_beats;
  int n_owner, n_last, n_beats;
  int beat_who;

  function automatic int rr_pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = 3;
    m_beats = 0;
  endtask

  task automatic model_eval();
    int w;
    beat_who = -1;
    n_owner  = m_owner;
    n_last   = m_last;
    n_beats  = m_beats;
    if (m_owner >= 0 && req[m_owner] && ready) begin
      beat_who = m_owner;
      sb.push_back({2'(m_owner), data[m_owner*8 +: 8]});
    end
    w = rr_pick(req, m_last);
    if (m_owner < 0) begin
      if (w >= 0) begin
        n_owner = w; n_last = w; n_beats = 0;
      end
    end else if (beat_who >= 0) begin
      if (m_beats + 1 < BurstLimit) begin
        n_beats = m_beats + 1;
      end else if (w >= 0) begin
        n_owner = w; n_last = w; n_beats = 0;
      end else begin
        n_owner = -1;
      end
    end else if (!req[m_owner]) begin
      n_owner = -1;
    end
  endtask

  // Drive one cycle of inputs, predict its outcome, and advance to just after the next edge.
  task automatic step(input logic [3:0] r, input logic [31:0] d, input logic rd);
    req   = r;
    data  = d;
    ready = rd;
    #1;
    model_eval();
    @(posedge clk);
    m_owner = n_owner;
    m_last  = n_last;
    m_beats = n_beats;
    #2;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    ready = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Monitor: each DUT beat must match the next predicted beat, and ack must be silent
  // on every other cycle.
  always @(negedge clk) begin
    logic [9:0] exp;
    logic [3:0] oh;
    if (rst_n) begin
      total++;
      if (o_valid && ready) begin
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL beat_unexpected sel=%0d data=%h exp=none", o_sel, o_data);
        end else begin
          exp = sb.pop_front();
          oh  = 4'b0001 << exp[9:8];
          if ({o_sel, o_data} !== exp || o_gnt !== oh || o_ack !== oh) begin
            bad++;
            $display("FAIL beat sel=%0d data=%h gnt=%b ack=%b exp sel=%0d data=%h gnt/ack=%b",
                     o_sel, o_data, o_gnt, o_ack, exp[9:8], exp[7:0], oh);
          end
        end
      end else if (o_ack !== 4'b0000) begin
        bad++;
        $display("FAIL ack_no_beat got=%b exp=0000", o_ack);
      end
    end
  end

  initial begin
    logic [3:0]  r;
    logic [31:0] d;
    logic        act[4];
    logic [7:0]  dat[4];

    // Reset state.
    rst_n = 1'b0;
    req   = 4'b0000;
    ready = 1'b0;
    data  = 32'hA5C3_7E19;
    model_reset();
    #1;
    check("reset_gnt", 32'(o_gnt), 32'h0);
    check("reset_valid", 32'(o_valid), 32'h0);
    check("reset_ack", 32'(o_ack), 32'h0);
    check("reset_sel", 32'(o_sel), 32'h0);
    check("reset_data", 32'(o_data), 32'h19);
    do_reset();

    // Single request: granted with a beat in the following cycle.
    step(4'b0010, 32'h0000_0200, 1'b1);
    #1;
    check("first_gnt", 32'(o_gnt), 32'h2);
    check("first_sel", 32'(o_sel), 32'h1);
    check("first_valid", 32'(o_valid), 32'h1);
    check("first_data", 32'(o_data), 32'h02);
    check("first_ack", 32'(o_ack), 32'h2);
    step(4'b0010, 32'h0000_0200, 1'b1);
    step(4'b0000, 32'h0, 1'b1);

    // All four request from reset: beats rotate 0,1,2,3,0,...
    do_reset();
    for (int i = 0; i < 7; i++) step(4'b1111, 32'h0403_0201, 1'b1);
    step(4'b0000, 32'h0, 1'b1);

    // Stall: grant and data hold while ready is low.
    do_reset();
    step(4'b0100, 32'h0003_0000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(4'b0100, 32'h0003_0000, 1'b0);
      #1;
      check("stall_data", 32'(o_data), 32'h03);
      check("stall_gnt", 32'(o_gnt), 32'h4);
    end
    step(4'b0100, 32'h0003_0000, 1'b1);
    step(4'b0000, 32'h0, 1'b1);

    // Withdrawal: requester 1 drops, requester 3 is granted two cycles later.
    do_reset();
    step(4'b0010, 32'h4400_1100, 1'b1);
    step(4'b0010, 32'h4400_1100, 1'b0);
    step(4'b1000, 32'h4400_1100, 1'b0);
    step(4'b1000, 32'h4400_1100, 1'b1);
    #1;
    check("withdraw_gnt", 32'(o_gnt), 32'h8);
    step(4'b1000, 32'h4400_1100, 1'b1);
    step(4'b0000, 32'h0, 1'b1);

    // Two persistent requesters: alternate, or alternate in bursts when bursts are enabled.
    do_reset();
    for (int i = 0; i < 12; i++) step(4'b0011, 32'h0000_BBAA, 1'b1);
    step(4'b0000, 32'h0, 1'b1);

    // Asynchronous reset during a stall drops everything before the next edge.
    do_reset();
    step(4'b0100, 32'h0077_0000, 1'b1);
    step(4'b0100, 32'h0077_0000, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_gnt", 32'(o_gnt), 32'h0);
    check("async_valid", 32'(o_valid), 32'h0);
    check("async_ack", 32'(o_ack), 32'h0);
    model_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step(4'b1111, 32'h0403_0201, 1'b0);
    #1;
    check("after_reset_gnt", 32'(o_gnt), 32'h1);
    step(4'b1111, 32'h0403_0201, 1'b1);
    step(4'b0000, 32'h0, 1'b1);

    // Random traffic: requesters hold request and data until the model says they were acked.
    for (int k = 0; k < 4; k++) begin
      act[k] = 1'b0;
      dat[k] = 8'h00;
    end
    for (int i = 0; i < 800; i++) begin
      d = $urandom();
      for (int k = 0; k < 4; k++) begin
        r[k] = act[k];
        if (act[k]) d[8*k +: 8] = dat[k];
      end
      step(r, d, ($urandom_range(0, 3) != 0));
      for (int k = 0; k < 4; k++) begin
        if (k == beat_who) begin
          act[k] = ($urandom_range(0, 1) == 1);
          dat[k] = 8'($urandom());
        end else if (!act[k]) begin
          if ($urandom_range(0, 2) == 0) begin
            act[k] = 1'b1;
            dat[k] = 8'($urandom());
          end
        end else if ($urandom_range(0, 39) == 0) begin
          act[k] = 1'b0;
        end
      end
    end
    for (int i = 0; i < 3; i++) step(4'b0000, 32'h0, 1'b1);
    #5;

    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
